// File: rtl/gpr_file.sv
// Two-read, one-write register file: one-hot write decoder, per-entry enabled registers, combinational reads.
// Define ZERO_REG_EN to hard-wire entry 0 to zero (RV32I x0 semantics).
module gpr_file #(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rdAddr0,
  input  logic [ADDR_WIDTH-1:0] rdAddr1,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [REG_WIDTH-1:0]  wrData,
  input  logic                  wrEna,
  output logic [REG_WIDTH-1:0]  rdData0,
  output logic [REG_WIDTH-1:0]  rdData1
);

  localparam int NUM_ENTRIES = 1 << ADDR_WIDTH;

  logic [NUM_ENTRIES-1:0] wrDec;
  logic [REG_WIDTH-1:0]   regs_q [NUM_ENTRIES];
  logic [REG_WIDTH-1:0]   regs_d [NUM_ENTRIES];

  always_comb begin
    wrDec = '0;
    if (wrEna) begin
      wrDec[wrAddr] = 1'b1;
    end
`ifdef ZERO_REG_EN
    // Writes to x0 are dropped at the decoder so entry 0 never leaves its reset value.
    wrDec[0] = 1'b0;
`endif
  end

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (wrDec[i]) begin
        regs_d[i] = wrData;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // No write-to-read bypass: reads see the stored value until the clock edge commits a write.
  always_comb begin
    rdData0 = regs_q[rdAddr0];
    rdData1 = regs_q[rdAddr1];
`ifdef ZERO_REG_EN
    if (rdAddr0 == '0) begin
      rdData0 = '0;
    end
    if (rdAddr1 == '0) begin
      rdData1 = '0;
    end
`endif
  end

endmodule

// File: tb/tb_gpr_file.sv
// Scoreboard bench for gpr_file: stimulus pushes expected read data, a negedge monitor pops and compares.
// Expectations for entry 0 follow ZERO_REG_EN when it is defined for the build.
module tb_gpr_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rdAddr0, rdAddr1, wrAddr;
  logic [31:0] wrData;
  logic        wrEna;
  logic [31:0] rdData0, rdData1;

  int compareCount  = 0;
  int mismatchCount = 0;

  typedef struct {
    string       name;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } expect_t;

  expect_t expQ[$];

  gpr_file #(.REG_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .rdAddr0 (rdAddr0),
    .rdAddr1 (rdAddr1),
    .wrAddr  (wrAddr),
    .wrData  (wrData),
    .wrEna   (wrEna),
    .rdData0 (rdData0),
    .rdData1 (rdData1)
  );

  always #5 clk = ~clk;

  // Monitor: reads are combinational, so every negedge with a pending expectation is a sample point.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      expect_t e;
      e = expQ.pop_front();
      compareCount++;
      if (rdData0 !== e.exp0) begin
        mismatchCount++;
        $display("[TB] FAIL %s port0: got %08h expected %08h", e.name, rdData0, e.exp0);
      end
      compareCount++;
      if (rdData1 !== e.exp1) begin
        mismatchCount++;
        $display("[TB] FAIL %s port1: got %08h expected %08h", e.name, rdData1, e.exp1);
      end
    end
  end

  task automatic applyStimulus(input logic en, input logic [4:0] addr, input logic [31:0] data);
    @(posedge clk);
    #1;
    wrEna  = en;
    wrAddr = addr;
    wrData = data;
  endtask

  task automatic checkOutput(input string name, input logic [4:0] a0, input logic [4:0] a1,
                             input logic [31:0] e0, input logic [31:0] e1);
    expect_t e;
    rdAddr0 = a0;
    rdAddr1 = a1;
    e.name = name;
    e.exp0 = e0;
    e.exp1 = e1;
    expQ.push_back(e);
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] sweepVal(input int idx);
    return (idx == 0) ? 32'h0 : 32'h100 + idx;
  endfunction

  logic [31:0] zeroExp;

  initial begin
    rst = 1'b0;
    rdAddr0 = '0;
    rdAddr1 = '0;
    wrAddr = '0;
    wrData = '0;
    wrEna = 1'b0;
`ifdef ZERO_REG_EN
    zeroExp = 32'h0;
`else
    zeroExp = 32'hFFFF_FFFF;
`endif

    #1;
    checkOutput("resetInit", 5'd0, 5'd31, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Async reset clears a written entry without a clock edge.
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 5'd0, 32'h0);
    checkOutput("write5", 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rstAsync", 5'd5, 5'd5, 32'h0, 32'h0);

    // Write edge while reset is held low must be ignored.
    wrEna  = 1'b1;
    wrAddr = 5'd9;
    wrData = 32'h55;
    @(posedge clk);
    #1;
    wrEna = 1'b0;
    rst   = 1'b1;
    checkOutput("rstEdge", 5'd9, 5'd5, 32'h0, 32'h0);

    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b1, 5'(i), 32'h100 + i);
    end
    applyStimulus(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      checkOutput("sweep", 5'(i), 5'(31 - i), sweepVal(i), sweepVal(31 - i));
    end

    applyStimulus(1'b0, 5'd7, 32'h1234_5678);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("wrEnaGate", 5'd7, 5'd8, 32'h107, 32'h108);

    applyStimulus(1'b1, 5'd3, 32'hA);
    applyStimulus(1'b1, 5'd3, 32'hB);
    checkOutput("rdDuringWrOld", 5'd3, 5'd3, 32'hA, 32'hA);
    applyStimulus(1'b0, 5'd0, 32'h0);
    checkOutput("rdDuringWrNew", 5'd3, 5'd3, 32'hB, 32'hB);

    applyStimulus(1'b1, 5'd12, 32'h1);
    applyStimulus(1'b1, 5'd12, 32'h2);
    applyStimulus(1'b0, 5'd0, 32'h0);
    checkOutput("lastWriteWins", 5'd12, 5'd11, 32'h2, 32'h10B);

    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 5'd0, 32'h0);
    checkOutput("entry0", 5'd0, 5'd0, zeroExp, zeroExp);

    for (int k = 0; k < 5 && expQ.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (expQ.size() > 0) begin
      mismatchCount++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/gpr_file.md
# gpr_file

Two-read, one-write general-purpose register file for the processor datapath, holding 32 entries of REG_WIDTH bits. Built from a binary-to-one-hot write decoder and per-entry enabled registers, with two independent combinational read ports. Sits between instruction decode (source/destination indices) and the execute/writeback stages.

## Interface
- REG_WIDTH, 32, data width of each entry and of all data ports
- ADDR_WIDTH, 5, index width; entry count is 2**ADDR_WIDTH (32); other values unsupported
- clk  input  1  rising-edge clock for all writes
- rst  input  1  asynchronous, active-low reset; clears every entry while low
- rdAddr0  input  ADDR_WIDTH  index for read port 0
- rdAddr1  input  ADDR_WIDTH  index for read port 1
- wrAddr  input  ADDR_WIDTH  index for the write port
- wrData  input  REG_WIDTH  write data
- wrEna  input  1  write enable, active-high
- rdData0  output  REG_WIDTH  contents of entry rdAddr0
- rdData1  output  REG_WIDTH  contents of entry rdAddr1

One clock; reset is asynchronous and active-low.

## Operation
- Write decoder: produces 32-bit one-hot enable vector; bit wrAddr set only when wrEna=1; all-zero when wrEna=0.
- Each entry: REG_WIDTH-bit register, loads wrData on rising clk when its decoder bit is 1; holds otherwise.
- At most one entry written per cycle.
- Read ports: pure combinational muxes; rdData0 = entry[rdAddr0], rdData1 = entry[rdAddr1]; both ports may address the same entry.
- Data treated as raw bits; no sign extension or arithmetic.
- Entry 0 behaviour governed by Configuration.

## Timing
- Reset: rst low asynchronously forces every writable entry to 0; rdData0/rdData1 reflect 0 combinationally (entry 0 per Configuration). Writes ignored while rst low, including a clock edge coinciding with rst low.
- Reset asserted mid-write: reset wins; entry stays 0.
- Write latency: data written at edge N is visible on read ports immediately after edge N (combinationally, same cycle after the edge).
- Read-during-write to same index before the edge: read returns the old value; no write-to-read bypass.
- Read latency: zero cycles (combinational from rdAddr to rdData).
- Consecutive writes to the same index: last write wins, one per cycle.
- wrEna=0: no entry changes regardless of wrAddr/wrData.

## Configuration
- ZERO_REG_EN defined: entry 0 is hard-wired to 0; writes to index 0 are discarded; reads of index 0 always return 0 (RV32I x0 semantics), including during and after reset.
- ZERO_REG_EN undefined: entry 0 is an ordinary writable register identical to entries 1-31 (reset to 0, writable).

## Test plan
- Reset: drive rst=0 mid-simulation after writing 0xDEADBEEF to entry 5 -> rdData0 for rdAddr0=5 reads 0 without a clock edge; stays 0 until written after rst=1.
- Write/read all: write value 0x100+i to entries 1-31 on consecutive cycles, then sweep rdAddr0 and rdAddr1 (rdAddr1 reversed) -> each returns 0x100+index.
- Write enable gating: wrEna=0, wrAddr=7, wrData=0x12345678 for several edges -> entry 7 keeps previous value.
- Read-during-write: entry 3 holds 0xA; set wrAddr=3, wrData=0xB, wrEna=1, rdAddr0=rdAddr1=3 -> reads 0xA before the edge, 0xB after.
- Entry 0 with ZERO_REG_EN: write 0xFFFFFFFF to index 0 -> rdData0=0; without the macro -> rdData0=0xFFFFFFFF.
- Reset vs. clock edge: rst low during a write edge to entry 9 with 0x55 -> entry 9 reads 0 after rst released.
